// File: rtl/serial_bus_master.sv
// UART-driven bus initiator: decodes A/W/R/P byte commands and issues word reads/writes.
// Optional inter-byte timeout in ARG is enabled by defining SERIAL_BUS_MASTER_TIMEOUT_EN.
module serial_bus_master
`ifdef SERIAL_BUS_MASTER_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 32'd4_000_000)
`endif
  (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_attention,
  output logic [7:0]  tx_d,
  output logic        tx_w,
  input  logic        tx_busy,
  output logic [29:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [31:0] bus_wrdata,
  output logic [3:0]  bus_wrmask,
  input  logic        bus_wait,
  input  logic [31:0] bus_rddata,
  input  logic        bus_rdvalid
);

  typedef enum logic [2:0] {IDLE, ARG, BUSWR, BUSRD, RDWAIT, TX} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] arg_q, arg_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  argcnt_q, argcnt_d;
  logic        iswr_q, iswr_d;
  logic [2:0]  txcnt_q, txcnt_d;
  logic        tx_w_q, tx_w_d;
  logic [7:0]  tx_d_q, tx_d_d;
  logic        bus_rd_q, bus_rd_d;
  logic        bus_wr_q, bus_wr_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wrdata_q, bus_wrdata_d;
  logic [31:0] arg_next;
  logic        accept;
  logic        timeout;

  assign arg_next = {arg_q[23:0], rx_data};
  assign accept   = (bus_rd_q | bus_wr_q) & ~bus_wait;

`ifdef SERIAL_BUS_MASTER_TIMEOUT_EN
  logic [31:0] gap_q, gap_d;

  always_comb begin
    gap_d = '0;
    if (!rx_attention && state_q == ARG) gap_d = gap_q + 32'd1;
  end

  assign timeout = (state_q == ARG) && !rx_attention && (gap_q == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_q <= '0;
    else        gap_q <= gap_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    arg_d        = arg_q;
    shift_d      = shift_q;
    argcnt_d     = argcnt_q;
    iswr_d       = iswr_q;
    txcnt_d      = txcnt_q;
    tx_w_d       = 1'b0;
    tx_d_d       = tx_d_q;
    bus_rd_d     = bus_rd_q;
    bus_wr_d     = bus_wr_q;
    bus_addr_d   = bus_addr_q;
    bus_wrdata_d = bus_wrdata_q;
    case (state_q)
      IDLE: begin
        if (rx_attention) begin
          case (rx_data)
            8'h41, 8'h57: begin
              state_d  = ARG;
              argcnt_d = 2'd0;
              iswr_d   = (rx_data == 8'h57);
            end
            8'h52: begin
              state_d    = BUSRD;
              bus_rd_d   = 1'b1;
              bus_addr_d = addr_q[31:2];
            end
            8'h50: begin
              state_d = TX;
              shift_d = {8'h4B, 24'h0};
              txcnt_d = 3'd1;
            end
            default: ;
          endcase
        end
      end
      ARG: begin
        if (timeout) begin
          state_d = IDLE;
          arg_d   = '0;
        end else if (rx_attention) begin
          arg_d    = arg_next;
          argcnt_d = argcnt_q + 2'd1;
          if (argcnt_q == 2'd3) begin
            if (iswr_q) begin
              state_d      = BUSWR;
              bus_wr_d     = 1'b1;
              bus_addr_d   = addr_q[31:2];
              bus_wrdata_d = arg_next;
            end else begin
              state_d = IDLE;
              addr_d  = {arg_next[31:2], 2'b00};
            end
          end
        end
      end
      BUSWR: begin
        if (accept) begin
          bus_wr_d = 1'b0;
          addr_d   = addr_q + 32'd4;
          shift_d  = {8'h2E, 24'h0};
          txcnt_d  = 3'd1;
          state_d  = TX;
        end
      end
      BUSRD: begin
        if (accept) begin
          bus_rd_d = 1'b0;
          state_d  = RDWAIT;
        end
      end
      RDWAIT: begin
        // The first byte leaves straight from the read data so tx_w follows bus_rdvalid by one cycle
        if (bus_rdvalid) begin
          addr_d  = addr_q + 32'd4;
          state_d = TX;
          if (!tx_busy) begin
            tx_w_d  = 1'b1;
            tx_d_d  = bus_rddata[31:24];
            shift_d = {bus_rddata[23:0], 8'h00};
            txcnt_d = 3'd3;
          end else begin
            shift_d = bus_rddata;
            txcnt_d = 3'd4;
          end
        end
      end
      TX: begin
        if (!tx_busy && !tx_w_q) begin
          tx_w_d  = 1'b1;
          tx_d_d  = shift_q[31:24];
          shift_d = {shift_q[23:0], 8'h00};
          txcnt_d = txcnt_q - 3'd1;
          if (txcnt_q == 3'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      arg_q        <= '0;
      shift_q      <= '0;
      argcnt_q     <= '0;
      iswr_q       <= 1'b0;
      txcnt_q      <= '0;
      tx_w_q       <= 1'b0;
      tx_d_q       <= '0;
      bus_rd_q     <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wrdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      arg_q        <= arg_d;
      shift_q      <= shift_d;
      argcnt_q     <= argcnt_d;
      iswr_q       <= iswr_d;
      txcnt_q      <= txcnt_d;
      tx_w_q       <= tx_w_d;
      tx_d_q       <= tx_d_d;
      bus_rd_q     <= bus_rd_d;
      bus_wr_q     <= bus_wr_d;
      bus_addr_q   <= bus_addr_d;
      bus_wrdata_q <= bus_wrdata_d;
    end
  end

  assign tx_w       = tx_w_q;
  assign tx_d       = tx_d_q;
  assign bus_rd     = bus_rd_q;
  assign bus_wr     = bus_wr_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wrdata = bus_wrdata_q;
  assign bus_wrmask = 4'hF;

endmodule

// File: tb/tb_serial_bus_master.sv
// Scoreboard bench for serial_bus_master: a host model queues expected replies and bus
// transactions; a bus responder and a transmit monitor pop and compare them.
module tb_serial_bus_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_attention;
  logic [7:0]  tx_d;
  logic        tx_w;
  logic        tx_busy;
  logic [29:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_wrdata;
  logic [3:0]  bus_wrmask;
  logic        bus_wait;
  logic [31:0] bus_rddata;
  logic        bus_rdvalid;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Scoreboard queues filled by the host model
  logic [7:0]  expTx[$];
  logic [61:0] expWr[$];
  logic [29:0] expRd[$];

  logic [31:0] modelAddr = 32'h0;
  logic [31:0] modelMem[logic [29:0]];
  logic [31:0] busMem[logic [29:0]];

  // Environment knobs and observation stamps
  int stallCycles = 0;
  int rdDelay = 1;
  bit rdDelayRand = 1'b0;
  bit randWait = 1'b0;
  bit busyRand = 1'b0;
  bit busyForce = 1'b0;
  bit spuriousEn = 1'b0;
  bit randGap = 1'b0;
  bit rdPending = 1'b0;
  int lastStrobeCyc = 0;
  int reqRiseCyc = 0;
  int acceptCyc = 0;
  int lastRdCyc = 0;
  int lastTxCyc = 0;
  int rdToTxGap = 0;
  bit txSinceRd = 1'b1;
  int txCount = 0;

`ifdef SERIAL_BUS_MASTER_TIMEOUT_EN
  serial_bus_master #(.TIMEOUT_CYCLES(16)) dut (
`else
  serial_bus_master dut (
`endif
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_attention(rx_attention),
    .tx_d(tx_d), .tx_w(tx_w), .tx_busy(tx_busy),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_wrdata(bus_wrdata),
    .bus_wrmask(bus_wrmask), .bus_wait(bus_wait), .bus_rddata(bus_rddata),
    .bus_rdvalid(bus_rdvalid));

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  function automatic logic [31:0] fillWord(input logic [29:0] w);
    return {w, 2'b00} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic flagFail(input string name, input int got);
    checks++;
    failures++;
    $display("[TB] FAIL %s got=%0d exp=none", name, got);
  endtask

  // Host side: one byte per strobe, optionally with idle gaps
  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_attention = 1'b1;
    lastStrobeCyc = cyc;
    @(posedge clk); #1;
    rx_attention = 1'b0;
    rx_data = 8'($urandom);
    if (randGap) repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic sendWord(input logic [31:0] v);
    applyStimulus(v[31:24]);
    applyStimulus(v[23:16]);
    applyStimulus(v[15:8]);
    applyStimulus(v[7:0]);
  endtask

  task automatic cmdAddr(input logic [31:0] a);
    modelAddr = {a[31:2], 2'b00};
    applyStimulus(8'h41);
    sendWord(a);
  endtask

  task automatic cmdWrite(input logic [31:0] d);
    expWr.push_back({modelAddr[31:2], d});
    modelMem[modelAddr[31:2]] = d;
    expTx.push_back(8'h2E);
    modelAddr = modelAddr + 32'd4;
    applyStimulus(8'h57);
    sendWord(d);
  endtask

  task automatic cmdRead();
    logic [29:0] w;
    logic [31:0] d;
    w = modelAddr[31:2];
    d = modelMem.exists(w) ? modelMem[w] : fillWord(w);
    expRd.push_back(w);
    expTx.push_back(d[31:24]);
    expTx.push_back(d[23:16]);
    expTx.push_back(d[15:8]);
    expTx.push_back(d[7:0]);
    modelAddr = modelAddr + 32'd4;
    applyStimulus(8'h52);
  endtask

  task automatic cmdPing();
    expTx.push_back(8'h4B);
    applyStimulus(8'h50);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    modelMem[a[31:2]] = v;
    busMem[a[31:2]] = v;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while ((expTx.size() + expWr.size() + expRd.size()) != 0 && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    if (n >= maxCycles) begin
      flagFail("drainTimeout", expTx.size() + expWr.size() + expRd.size());
      expTx.delete();
      expWr.delete();
      expRd.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  // Transmitter side: busy pattern
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_busy = busyForce ? 1'b1 : (busyRand ? ($urandom_range(0, 2) == 0) : 1'b0);
    end
  end

  // Transmit monitor: every tx_w pops one expected byte
  initial begin
    bit prevTxW;
    bit prevBusy;
    prevTxW = 1'b0;
    prevBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevTxW = 1'b0;
        prevBusy = 1'b0;
      end else begin
        if (bus_rdvalid) begin
          lastRdCyc = cyc;
          txSinceRd = 1'b0;
        end
        if (tx_w) begin
          txCount++;
          lastTxCyc = cyc;
          if (!txSinceRd) begin
            rdToTxGap = cyc - lastRdCyc;
            txSinceRd = 1'b1;
          end
          checkOutput("txSpacing", 64'(prevTxW), 64'd0);
          checkOutput("txBusyRespect", 64'(prevBusy), 64'd0);
          if (expTx.size() == 0) flagFail("unexpectedTx", int'(tx_d));
          else checkOutput("txByte", 64'(tx_d), 64'(expTx.pop_front()));
        end
        prevTxW = tx_w;
        prevBusy = tx_busy;
      end
    end
  end

  // Bus responder: stalls, accepts, checks requests and returns read data
  initial begin
    int cnt;
    bit nextRv;
    bit nextWait;
    bit prevStalled;
    bit prevRd;
    logic [63:0] prevReq;
    logic [31:0] word;
    logic [61:0] e;
    cnt = 0;
    prevStalled = 1'b0;
    prevRd = 1'b0;
    prevReq = '0;
    word = '0;
    bus_wait = 1'b0;
    bus_rdvalid = 1'b0;
    bus_rddata = '0;
    forever begin
      @(negedge clk);
      nextRv = 1'b0;
      if (!rst_n) begin
        rdPending = 1'b0;
        prevStalled = 1'b0;
        prevRd = 1'b0;
      end else begin
        if (prevStalled)
          checkOutput("reqStable", {bus_rd, bus_wr, bus_addr, bus_wrdata}, prevReq);
        if (bus_rd && !prevRd) reqRiseCyc = cyc;
        prevRd = bus_rd;
        if ((bus_rd || bus_wr) && bus_wait) begin
          prevStalled = 1'b1;
          prevReq = {bus_rd, bus_wr, bus_addr, bus_wrdata};
          if (stallCycles > 0) stallCycles--;
        end else begin
          prevStalled = 1'b0;
        end
        if (bus_rd && !bus_wait) begin
          acceptCyc = cyc;
          if (expRd.size() == 0) flagFail("unexpectedRead", int'(bus_addr));
          else checkOutput("readAddr", 64'(bus_addr), 64'(expRd.pop_front()));
          word = busMem.exists(bus_addr) ? busMem[bus_addr] : fillWord(bus_addr);
          rdPending = 1'b1;
          cnt = rdDelayRand ? $urandom_range(1, 4) : rdDelay;
        end
        if (bus_wr && !bus_wait) begin
          acceptCyc = cyc;
          if (expWr.size() == 0) begin
            flagFail("unexpectedWrite", int'(bus_addr));
          end else begin
            e = expWr.pop_front();
            checkOutput("writeAddr", 64'(bus_addr), 64'(e[61:32]));
            checkOutput("writeData", 64'(bus_wrdata), 64'(e[31:0]));
            checkOutput("writeMask", 64'(bus_wrmask), 64'hF);
          end
          busMem[bus_addr] = bus_wrdata;
        end
        if (rdPending) begin
          if (cnt <= 1) begin
            nextRv = 1'b1;
            rdPending = 1'b0;
          end else begin
            cnt--;
          end
        end else if (spuriousEn && !bus_rd && $urandom_range(0, 40) == 0) begin
          nextRv = 1'b1;
          word = $urandom;
        end
      end
      nextWait = (stallCycles > 0) ? 1'b1 : (randWait && $urandom_range(0, 2) == 0);
      @(posedge clk); #1;
      bus_wait = nextWait;
      bus_rdvalid = nextRv;
      bus_rddata = nextRv ? word : $urandom;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=%0d exp=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sR;
    int c0;
    int t0;
    int n;
    logic [7:0] junk;
    logic [31:0] a;
    rx_data = 8'h00;
    rx_attention = 1'b0;

    // Reset values
    repeat (3) @(posedge clk); #1;
    checkOutput("rstCtrl", {61'd0, bus_rd, bus_wr, tx_w}, 64'd0);
    checkOutput("rstTxD", 64'(tx_d), 64'd0);
    checkOutput("rstBusAddr", 64'(bus_addr), 64'd0);
    checkOutput("rstWrData", 64'(bus_wrdata), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Ping with an idle transmitter
    c0 = txCount;
    cmdPing();
    sR = lastStrobeCyc;
    waitDrain(100);
    checkOutput("pingLatency", 64'(lastTxCyc - sR), 64'd2);
    checkOutput("pingCount", 64'(txCount - c0), 64'd1);

    // Write with unaligned address, then read back at the incremented address
    cmdAddr(32'h0000_1003);
    cmdWrite(32'hDEAD_BEEF);
    waitDrain(100);
    cmdRead();
    waitDrain(100);

    // Read under stall
    preload(32'h0000_1000, 32'h1234_5678);
    cmdAddr(32'h0000_1000);
    stallCycles = 5;
    rdDelay = 3;
    cmdRead();
    sR = lastStrobeCyc;
    waitDrain(200);
    checkOutput("rdReqLatency", 64'(reqRiseCyc - sR), 64'd1);
    checkOutput("rdStallLen", 64'(acceptCyc - reqRiseCyc), 64'd5);
    checkOutput("rdToTxLatency", 64'(rdToTxGap), 64'd1);
    rdDelay = 1;
    cmdRead();
    waitDrain(100);

    // Address wrap
    cmdAddr(32'hFFFF_FFFC);
    cmdRead();
    waitDrain(100);
    cmdRead();
    waitDrain(100);

    // Flow control: busy for 100 cycles, P sent during the reply is dropped
    cmdAddr(32'h0000_2000);
    busyForce = 1'b1;
    t0 = cyc;
    c0 = txCount;
    cmdRead();
    n = 0;
    while ((expRd.size() != 0 || rdPending) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) flagFail("rdTimeout", n);
    repeat (4) @(posedge clk);
    applyStimulus(8'h50);
    while (cyc - t0 < 100) @(posedge clk);
    checkOutput("busyHoldsTx", 64'(txCount - c0), 64'd0);
    busyForce = 1'b0;
    waitDrain(200);
    checkOutput("busyReplyLen", 64'(txCount - c0), 64'd4);

    // Byte arriving during a stalled write is dropped
    cmdAddr(32'h0000_0200);
    stallCycles = 8;
    c0 = txCount;
    cmdWrite(32'hCAFE_F00D);
    applyStimulus(8'h50);
    waitDrain(200);
    checkOutput("wrDropReply", 64'(txCount - c0), 64'd1);

`ifdef SERIAL_BUS_MASTER_TIMEOUT_EN
    // Partial W command abandoned by the gap timer
    c0 = txCount;
    applyStimulus(8'h57);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    repeat (20) @(posedge clk);
    cmdPing();
    waitDrain(100);
    checkOutput("timeoutReply", 64'(txCount - c0), 64'd1);
`endif

    // Reset in the middle of a stalled read
    cmdAddr(32'h0000_0040);
    stallCycles = 1000;
    applyStimulus(8'h52);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("stallHeld", 64'(bus_rd), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstRd", 64'(bus_rd), 64'd0);
    checkOutput("asyncRstAddr", 64'(bus_addr), 64'd0);
    stallCycles = 0;
    modelAddr = 32'h0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    cmdRead();
    waitDrain(100);

    // Randomised command stream
    randWait = 1'b1;
    busyRand = 1'b1;
    rdDelayRand = 1'b1;
    spuriousEn = 1'b1;
    randGap = 1'b1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          a = $urandom;
          if ($urandom_range(0, 3) == 0) a = {30'h3FFF_FFFE + 30'($urandom_range(0, 1)), 2'($urandom)};
          cmdAddr(a);
        end
        2, 3: begin cmdWrite($urandom); waitDrain(2000); end
        6:    begin cmdPing(); waitDrain(2000); end
        7: begin
          junk = 8'($urandom);
          while (junk == 8'h41 || junk == 8'h57 || junk == 8'h52 || junk == 8'h50) junk = 8'($urandom);
          applyStimulus(junk);
        end
        default: begin cmdRead(); waitDrain(2000); end
      endcase
    end
    spuriousEn = 1'b0;
    repeat (10) @(posedge clk);

    checkOutput("queuesEmpty", 64'(expTx.size() + expWr.size() + expRd.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
